// File: rtl/config_rx_if.sv
// rtl/config_rx_if.sv - serial configuration link and decoded-word bundle for config_rx
interface config_rx_if #(
  parameter int C_NO_CFG_BITS = 24
);
  logic                     TX_CLK;
  logic                     TX_DAT;
  logic                     TX_OE_N;
  logic [C_NO_CFG_BITS-1:0] CFG_WORD;
  logic                     CFG_VALID;
  logic                     CFG_ERROR;
  logic                     BUSY;
`ifdef CONFIG_RX_WORD_COUNT_EN
  logic [15:0]              WORD_COUNT;
  logic [7:0]               ERROR_COUNT;

  modport master (output TX_CLK, TX_DAT, TX_OE_N,
                  input  CFG_WORD, CFG_VALID, CFG_ERROR, BUSY, WORD_COUNT, ERROR_COUNT);
  modport slave  (input  TX_CLK, TX_DAT, TX_OE_N,
                  output CFG_WORD, CFG_VALID, CFG_ERROR, BUSY, WORD_COUNT, ERROR_COUNT);
`else
  modport master (output TX_CLK, TX_DAT, TX_OE_N,
                  input  CFG_WORD, CFG_VALID, CFG_ERROR, BUSY);
  modport slave  (input  TX_CLK, TX_DAT, TX_OE_N,
                  output CFG_WORD, CFG_VALID, CFG_ERROR, BUSY);
`endif
endinterface

// File: rtl/config_rx.sv
// rtl/config_rx.sv - 3-wire config link receiver; CONFIG_RX_WORD_COUNT_EN adds word/error counters
module config_rx #(
  parameter int CLOCK_PERIOD_PS = 20833,
  parameter int BIT_PERIOD_NS   = 400,
  parameter int C_NO_CFG_BITS   = 24,
  parameter int TIMEOUT_BITS    = 4
) (
  input  logic        CLOCK,
  input  logic        RESET,
  config_rx_if.slave  link
);
  localparam int N              = C_NO_CFG_BITS;
  localparam int TIMEOUT_CYCLES = (TIMEOUT_BITS * BIT_PERIOD_NS * 1000) / CLOCK_PERIOD_PS;
  localparam int CW             = $clog2(N + 2);
  localparam int TW             = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, FLUSH} state_t;

  state_t         state, state_nxt;
  logic [2:0]     clk_sync;
  logic [1:0]     dat_sync;
  logic [1:0]     oe_sync;
  logic [N-1:0]   shreg, shreg_nxt;
  logic [CW-1:0]  bit_cnt, cnt_nxt;
  logic [TW-1:0]  tmo_cnt;
  logic [N-1:0]   cfg_word;
  logic           cfg_valid, cfg_error, busy;
  logic           clk_rise, dat, oe_n;
  logic           shift_rise, frame_end, frame_good, tmo_hit;

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      clk_sync <= '0;
      dat_sync <= '0;
      oe_sync  <= '1;
    end else begin
      clk_sync <= {clk_sync[1:0], link.TX_CLK};
      dat_sync <= {dat_sync[0], link.TX_DAT};
      oe_sync  <= {oe_sync[0], link.TX_OE_N};
    end
  end

  assign clk_rise = clk_sync[1] & ~clk_sync[2];
  assign dat      = dat_sync[1];
  assign oe_n     = oe_sync[1];

  // An edge landing in the end-of-frame cycle is folded in before the count is judged
  assign shift_rise = (state == SHIFT) && clk_rise;
  assign shreg_nxt  = shift_rise ? {shreg[N-2:0], dat} : shreg;
  assign cnt_nxt    = (shift_rise && bit_cnt != CW'(N + 1)) ? bit_cnt + CW'(1) : bit_cnt;
  assign frame_end  = (state == SHIFT) && oe_n;
  assign frame_good = frame_end && (cnt_nxt == CW'(N));
  assign tmo_hit    = (state == SHIFT) && !oe_n && !clk_rise && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!oe_n) state_nxt = SHIFT;
      SHIFT: begin
        if (oe_n)         state_nxt = IDLE;
        else if (tmo_hit) state_nxt = FLUSH;
      end
      FLUSH:   if (oe_n) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      shreg     <= '0;
      bit_cnt   <= '0;
      tmo_cnt   <= '0;
      cfg_word  <= '0;
      cfg_valid <= 1'b0;
      cfg_error <= 1'b0;
    end else begin
      cfg_valid <= frame_good;
      cfg_error <= (frame_end && !frame_good) || tmo_hit;
      if (frame_good) cfg_word <= shreg_nxt;
      // Holding the counters clear in IDLE gives a fresh start on every SHIFT entry
      if (state == IDLE) begin
        shreg   <= '0;
        bit_cnt <= '0;
        tmo_cnt <= '0;
      end else if (state == SHIFT) begin
        shreg   <= shreg_nxt;
        bit_cnt <= cnt_nxt;
        tmo_cnt <= clk_rise ? '0 : tmo_cnt + TW'(1);
      end
    end
  end

  assign link.CFG_WORD  = cfg_word;
  assign link.CFG_VALID = cfg_valid;
  assign link.CFG_ERROR = cfg_error;
  assign link.BUSY      = busy;

`ifdef CONFIG_RX_WORD_COUNT_EN
  logic [15:0] word_count;
  logic [7:0]  error_count;

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      word_count  <= '0;
      error_count <= '0;
    end else begin
      if (frame_good) word_count <= word_count + 16'd1;
      if (((frame_end && !frame_good) || tmo_hit) && error_count != 8'hFF)
        error_count <= error_count + 8'd1;
    end
  end

  assign link.WORD_COUNT  = word_count;
  assign link.ERROR_COUNT = error_count;
`endif
endmodule

// File: tb/tb_config_rx.sv
// tb/tb_config_rx.sv - table-driven scoreboard bench for config_rx
`timescale 1ns/1ps
module tb_config_rx;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  config_rx_if #(.C_NO_CFG_BITS(24)) link ();

  config_rx dut (
    .CLOCK (clk),
    .RESET (rst),
    .link  (link)
  );

  always #10.417 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] word;
    int          nbits;
    bit          coincident;
    bit          exp_valid;
  } vec_t;

  typedef struct {
    bit          is_valid;
    logic [23:0] word;
    bit          lat_oe;
    bit          lat_tmo;
  } exp_t;

  exp_t        sb[$];
  exp_t        got;
  logic [23:0] model_word = '0;
  int          oe_rise_cyc = 0;
  int          last_edge_cyc = 0;
  int          n_valid = 0;
  int          exp_n_valid = 0;
  bit          prev_strobe = 1'b0;

  task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      prev_strobe = 1'b0;
    end else begin
      if (link.CFG_VALID || link.CFG_ERROR) begin
        check(!(link.CFG_VALID && link.CFG_ERROR), "strobe_exclusive", {link.CFG_VALID, link.CFG_ERROR}, 0);
        check(!prev_strobe, "strobe_not_consecutive", prev_strobe, 0);
        if (link.CFG_VALID) n_valid++;
        if (sb.size() == 0) begin
          check(1'b0, "unexpected_strobe", {link.CFG_VALID, link.CFG_ERROR}, 0);
        end else begin
          got = sb.pop_front();
          check(link.CFG_VALID == got.is_valid, "strobe_kind_valid", link.CFG_VALID, got.is_valid);
          if (got.is_valid) model_word = got.word;
          check(link.CFG_WORD == model_word, "cfg_word", link.CFG_WORD, model_word);
          if (got.lat_oe)
            check((cyc - oe_rise_cyc) >= 3 && (cyc - oe_rise_cyc) <= 5, "oe_latency", cyc - oe_rise_cyc, 4);
          if (got.lat_tmo)
            check((cyc - last_edge_cyc) >= 77 && (cyc - last_edge_cyc) <= 81, "timeout_latency", cyc - last_edge_cyc, 79);
        end
      end
      prev_strobe = link.CFG_VALID || link.CFG_ERROR;
    end
  end

  task automatic push_exp(input bit is_valid, input logic [23:0] word, input bit lat_oe, input bit lat_tmo);
    exp_t e;
    e.is_valid = is_valid;
    e.word     = word;
    e.lat_oe   = lat_oe;
    e.lat_tmo  = lat_tmo;
    sb.push_back(e);
    if (is_valid) exp_n_valid++;
  endtask

  task automatic end_of_frame_checks(input string tag);
    int n;
    n = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      n++;
      if (!link.BUSY) break;
    end
    check(n <= 5, {tag, "_busy_drop"}, n, 5);
    #1000;
    check(sb.size() == 0, {tag, "_pending"}, sb.size(), 0);
  endtask

  task automatic send_frame(input logic [31:0] word, input int nbits, input bit coincident,
                            input bit exp_valid, input int rst_at, input string tag);
    link.TX_OE_N = 1'b0;
    #300;
    for (int i = 0; i < nbits; i++) begin
      link.TX_DAT = word[nbits-1-i];
      link.TX_CLK = 1'b0;
      if (i == rst_at) begin
        #50 rst = 1'b1;
        model_word = '0;
        #50 rst = 1'b0;
        #100;
      end else begin
        #200;
      end
      if (coincident && i == nbits - 1) begin
        push_exp(exp_valid, word[23:0], 1'b1, 1'b0);
        oe_rise_cyc   = cyc;
        last_edge_cyc = cyc;
        link.TX_CLK   = 1'b1;
        link.TX_OE_N  = 1'b1;
      end else begin
        last_edge_cyc = cyc;
        link.TX_CLK   = 1'b1;
      end
      #200;
    end
    if (!coincident) begin
      link.TX_CLK = 1'b0;
      #200;
      push_exp(exp_valid, word[23:0], 1'b1, 1'b0);
      oe_rise_cyc  = cyc;
      link.TX_OE_N = 1'b1;
    end
    end_of_frame_checks(tag);
    link.TX_CLK = 1'b0;
  endtask

  vec_t vecs[7];

  initial begin
    vecs[0] = '{32'h00A5C3F0, 24, 1'b0, 1'b1};
    vecs[1] = '{32'h00123456, 23, 1'b0, 1'b0};
    vecs[2] = '{32'h01ABCDEF, 25, 1'b0, 1'b0};
    vecs[3] = '{32'h005A5A5A, 24, 1'b1, 1'b1};
    vecs[4] = '{32'h00FFFFFF, 24, 1'b0, 1'b1};
    vecs[5] = '{32'h00000000, 24, 1'b0, 1'b1};
    vecs[6] = '{32'h00800001, 24, 1'b1, 1'b1};

    link.TX_CLK  = 1'b0;
    link.TX_DAT  = 1'b0;
    link.TX_OE_N = 1'b1;
    rst = 1'b1;
    repeat (4) @(negedge clk);
    check(link.CFG_WORD == 0,  "reset_cfg_word",  link.CFG_WORD, 0);
    check(link.CFG_VALID == 0, "reset_cfg_valid", link.CFG_VALID, 0);
    check(link.CFG_ERROR == 0, "reset_cfg_error", link.CFG_ERROR, 0);
    check(link.BUSY == 0,      "reset_busy",      link.BUSY, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    for (int v = 0; v < 7; v++) begin
      send_frame(vecs[v].word, vecs[v].nbits, vecs[v].coincident, vecs[v].exp_valid, -1,
                 $sformatf("vec%0d", v));
      #500;
    end

    // Stalled frame: clock stops after bit 10, OE_N held low ~3 us
    link.TX_OE_N = 1'b0;
    #300;
    for (int i = 0; i < 10; i++) begin
      link.TX_DAT = i[0];
      link.TX_CLK = 1'b0;
      #200;
      last_edge_cyc = cyc;
      link.TX_CLK = 1'b1;
      #200;
    end
    push_exp(1'b0, 24'h0, 1'b0, 1'b1);
    link.TX_CLK = 1'b0;
    #1800;
    repeat (2) begin
      link.TX_CLK = 1'b1;
      #200;
      link.TX_CLK = 1'b0;
      #200;
    end
    link.TX_OE_N = 1'b1;
    end_of_frame_checks("timeout");
    #500;

    send_frame(32'h00000001, 24, 1'b0, 1'b1, -1, "after_timeout");
    check(link.CFG_WORD == 24'h000001, "after_timeout_word", link.CFG_WORD, 24'h000001);
    #500;

    send_frame(32'h00C0FFEE, 24, 1'b0, 1'b0, 12, "reset_mid");
    check(link.CFG_WORD == 0, "reset_mid_word", link.CFG_WORD, 0);
    check(n_valid == exp_n_valid, "valid_count", n_valid, exp_n_valid);

`ifdef CONFIG_RX_WORD_COUNT_EN
    #500;
    rst = 1'b1;
    model_word = '0;
    #100 rst = 1'b0;
    #500;
    send_frame(32'h00111111, 24, 1'b0, 1'b1, -1, "wc0");
    send_frame(32'h00222222, 24, 1'b0, 1'b1, -1, "wc1");
    send_frame(32'h00333333, 24, 1'b0, 1'b1, -1, "wc2");
    send_frame(32'h00044444, 20, 1'b0, 1'b0, -1, "wc_short");
    check(link.WORD_COUNT == 16'd3, "word_count", link.WORD_COUNT, 3);
    check(link.ERROR_COUNT == 8'd1, "error_count", link.ERROR_COUNT, 1);
    @(negedge clk);
    force dut.word_count = 16'hFFFF;
    @(negedge clk);
    release dut.word_count;
    send_frame(32'h00555555, 24, 1'b0, 1'b1, -1, "wc_wrap");
    check(link.WORD_COUNT == 16'h0000, "word_count_wrap", link.WORD_COUNT, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end
endmodule

// File: doc/config_rx.md
Name: config_rx

Overview:
- Sensor-side receiver for the serial configuration link driven by the camera interface's configuration transmitter (TX_DAT / TX_CLK / TX_OE_N).
- Samples the 3-wire link in the 48 MHz system clock domain and deserializes one C_NO_CFG_BITS-bit configuration word per frame.
- Presents the word with a one-cycle valid strobe, and flags framing or timeout errors.
- Used as the sensor model in system benches and as the link checker in loopback builds.

Parameters:
- CLOCK_PERIOD_PS, 20833, system clock period (48 MHz).
- BIT_PERIOD_NS, 400, nominal link bit period (2.5 MHz).
- C_NO_CFG_BITS, 24, bits per configuration word; range 2..32.
- TIMEOUT_BITS, 4, stall timeout in bit periods.
  - Derived TIMEOUT_CYCLES = (TIMEOUT_BITS*BIT_PERIOD_NS*1000)/CLOCK_PERIOD_PS, integer division.
  - Defaults give 76.

Ports:
- CLOCK  in  1  system clock, 48 MHz.
- RESET  in  1  reset.
- TX_CLK  in  1  link bit clock, asynchronous to CLOCK; data is valid on the rising edge.
- TX_DAT  in  1  link serial data, MSB first.
- TX_OE_N  in  1  link frame enable, active low; a frame lasts while it is low.
- CFG_WORD  out  C_NO_CFG_BITS  last good word received.
- CFG_VALID  out  1  one-cycle strobe; CFG_WORD updated this cycle.
- CFG_ERROR  out  1  one-cycle strobe on framing error or timeout.
- BUSY  out  1  high while a frame is in progress (state != IDLE).

Interface (already decided): one clock, CLOCK; reset is RESET, asynchronous and active-high.

Behaviour:
- Reset values:
  - Outputs: CFG_WORD=0, CFG_VALID=0, CFG_ERROR=0, BUSY=0.
  - Internal: shift register 0, bit counter 0, timeout counter 0.
  - Sync flops: TX_OE_N chain resets to 1; TX_CLK and TX_DAT chains reset to 0.
  - FSM resets to IDLE.
- Input synchronization:
  - TX_CLK, TX_DAT and TX_OE_N each pass through a 2-flop synchronizer.
  - Rising-edge detect uses a third flop on the TX_CLK chain: clk_rise = s2 & ~s3.
  - TX_DAT is sampled from its s2 stage in the clk_rise cycle.
- FSM states: IDLE, SHIFT, FLUSH.
- IDLE:
  - Synchronized OE_N low -> SHIFT.
  - On entry to SHIFT: bit_cnt=0, timeout counter=0, shift register=0.
  - clk_rise while in IDLE is ignored.
- SHIFT, on clk_rise:
  - shreg <= {shreg[N-2:0], dat}.
  - bit_cnt increments, saturating at C_NO_CFG_BITS+1.
  - Timeout counter is cleared.
- SHIFT, otherwise: timeout counter increments.
- SHIFT, synchronized OE_N high: end of frame. The frame is evaluated in the same cycle.
  - A clk_rise in that same cycle is counted first.
  - If the resulting bit_cnt == C_NO_CFG_BITS: CFG_WORD <= resulting shreg and CFG_VALID=1 on the next cycle.
  - Otherwise CFG_ERROR=1 on the next cycle and CFG_WORD is unchanged.
  - Either way -> IDLE.
- SHIFT, timeout counter reaches TIMEOUT_CYCLES-1 with no clk_rise and OE_N still low:
  - CFG_ERROR=1 on the next cycle.
  - -> FLUSH.
- FLUSH:
  - Ignores clk_rise.
  - Waits for synchronized OE_N high -> IDLE, with no further strobe.
- Latency: CFG_VALID rises 4 CLOCK cycles after the TX_OE_N rising edge at the pin (2 sync + evaluate + register), ±1 cycle for synchronizer phase.
- CFG_VALID and CFG_ERROR are mutually exclusive and never high for two consecutive cycles.
- BUSY=1 in SHIFT and FLUSH.
- Back-to-back frames:
  - OE_N high for at least 2 synchronized cycles is required between frames.
  - A shorter high pulse may be missed. It then merges into one frame and is reported as an error by bit count.
- Reset asserted mid-frame: all state is cleared immediately.
  - If OE_N is still low after reset release, a new frame starts from bit 0.
  - A partial frame therefore yields CFG_ERROR at its end, never CFG_VALID.
- Minimum TX_CLK high and low time: 3 CLOCK cycles. At the nominal rates this is met with ~9 cycles per phase.

Optional Feature:
- Macro: CONFIG_RX_WORD_COUNT_EN.
- When defined, adds two outputs:
  - WORD_COUNT [15:0]: increments on each CFG_VALID and wraps 0xFFFF->0.
  - ERROR_COUNT [7:0]: increments on each CFG_ERROR and saturates at 0xFF.
  - Both reset to 0.
- When undefined, neither port nor logic exists. Core behaviour is identical in both builds.

Test Plan:
- Frame 0xA5C3F0 sent MSB first, 24 TX_CLK pulses at 2.5 MHz, OE_N framing -> exactly one CFG_VALID, CFG_WORD=0xA5C3F0, no CFG_ERROR, BUSY low again within 5 cycles of OE_N rise.
- Frame with 23 clocks, then one with 25 clocks -> two CFG_ERROR strobes, no CFG_VALID, CFG_WORD keeps its prior value.
- TX_CLK stops after bit 10 with OE_N held low for 3 µs -> one CFG_ERROR about 76 cycles after the last edge. Further TX_CLK edges are ignored until OE_N goes high. The next clean frame 0x000001 gives CFG_VALID.
- 24th TX_CLK rising edge coincident with the OE_N rising edge at the pins -> CFG_VALID with the correct word.
- RESET pulsed after bit 12 with OE_N held low through the remaining 12 bits -> CFG_ERROR at OE_N rise, CFG_WORD=0.
- With CONFIG_RX_WORD_COUNT_EN: 3 good frames, 1 short frame -> WORD_COUNT=3, ERROR_COUNT=1. Force WORD_COUNT=0xFFFF, then one good frame -> 0x0000.
